// File: rtl/alu.sv
// Execute-stage ALU with registered outputs: arithmetic/logic results, load/store
// effective address and memory flags, and branch/jump next-PC selection.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] i_data_2_ex,
    input  logic [31:0] pc4_out_2_ex,
    input  logic [4:0]  rd_add_value_2_ex,
    output logic [31:0] rd,
    output logic [31:0] A,
    output logic [31:0] pc4_out_2_ex_out,
    output logic        mem_read_2_ex,
    output logic        mem_to_reg_2_ex,
    output logic        mem_write_2_ex
);

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_SUBI = 6'b000011,
        OP_MUL  = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_ORI  = 6'b000111,
        OP_AND  = 6'b001000,
        OP_ANDI = 6'b001001,
        OP_XOR  = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101,
        OP_BZ   = 6'b001110,
        OP_BEQ  = 6'b001111,
        OP_JR   = 6'b010000,
        OP_HALT = 6'b010001
    } opcode_e;

    logic [31:0] rd_next;
    logic [31:0] a_next;
    logic [31:0] pc_next;
    logic        mem_read_next;
    logic        mem_to_reg_next;
    logic        mem_write_next;
    logic [31:0] branch_target;

    // The destination address only travels alongside the stage; it never affects results.
    logic unused_rd_add;
    assign unused_rd_add = ^rd_add_value_2_ex;

    assign branch_target = pc4_out_2_ex - 32'd4 + (i_data_2_ex << 2);

    always_comb begin
        rd_next         = 32'd0;
        a_next          = 32'd0;
        pc_next         = pc4_out_2_ex;
        mem_read_next   = 1'b0;
        mem_to_reg_next = 1'b0;
        mem_write_next  = 1'b0;
        case (op)
            OP_ADD:  rd_next = rs + rt;
            OP_ADDI: rd_next = rs + i_data_2_ex;
            OP_SUB:  rd_next = rs - rt;
            OP_SUBI: rd_next = rs - i_data_2_ex;
            OP_MUL:  rd_next = rs * rt;
            OP_MULI: rd_next = rs * i_data_2_ex;
            OP_OR:   rd_next = rs | rt;
            OP_ORI:  rd_next = rs | i_data_2_ex;
            OP_AND:  rd_next = rs & rt;
            OP_ANDI: rd_next = rs & i_data_2_ex;
            OP_XOR:  rd_next = rs ^ rt;
            OP_XORI: rd_next = rs ^ i_data_2_ex;
            OP_LDW: begin
                a_next          = rs + i_data_2_ex;
                mem_read_next   = 1'b1;
                mem_to_reg_next = 1'b1;
            end
            OP_STW: begin
                a_next         = rs + i_data_2_ex;
                rd_next        = rt;
                mem_write_next = 1'b1;
            end
            OP_BZ:   if (rs == 32'd0) pc_next = branch_target;
            OP_BEQ:  if (rs == rt)    pc_next = branch_target;
            OP_JR:   pc_next = rs;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd               <= 32'd0;
            A                <= 32'd0;
            pc4_out_2_ex_out <= 32'd0;
            mem_read_2_ex    <= 1'b0;
            mem_to_reg_2_ex  <= 1'b0;
            mem_write_2_ex   <= 1'b0;
        end else begin
            rd               <= rd_next;
            A                <= a_next;
            pc4_out_2_ex_out <= pc_next;
            mem_read_2_ex    <= mem_read_next;
            mem_to_reg_2_ex  <= mem_to_reg_next;
            mem_write_2_ex   <= mem_write_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu execute stage.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] i_data_2_ex;
    logic [31:0] pc4_out_2_ex;
    logic [4:0]  rd_add_value_2_ex;
    logic [31:0] rd;
    logic [31:0] A;
    logic [31:0] pc4_out_2_ex_out;
    logic        mem_read_2_ex;
    logic        mem_to_reg_2_ex;
    logic        mem_write_2_ex;

    int checks;
    int failures;

    alu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .op                (op),
        .rs                (rs),
        .rt                (rt),
        .i_data_2_ex       (i_data_2_ex),
        .pc4_out_2_ex      (pc4_out_2_ex),
        .rd_add_value_2_ex (rd_add_value_2_ex),
        .rd                (rd),
        .A                 (A),
        .pc4_out_2_ex_out  (pc4_out_2_ex_out),
        .mem_read_2_ex     (mem_read_2_ex),
        .mem_to_reg_2_ex   (mem_to_reg_2_ex),
        .mem_write_2_ex    (mem_write_2_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation on the falling edge, then return just after the capturing rising edge.
    task automatic apply_stimulus(input logic [5:0] o, input logic [31:0] s, input logic [31:0] t,
                                  input logic [31:0] imm, input logic [31:0] pc4);
        @(negedge clk);
        op                = o;
        rs                = s;
        rt                = t;
        i_data_2_ex       = imm;
        pc4_out_2_ex      = pc4;
        rd_add_value_2_ex = 5'd7;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        op = 6'b000000; rs = 32'h11; rt = 32'h22; i_data_2_ex = 32'h3;
        pc4_out_2_ex = 32'h200; rd_add_value_2_ex = 5'd1;
        #3;
        checks++;
        if ({rd, A, pc4_out_2_ex_out} !== 96'd0 ||
            {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b000) begin
            failures++;
            $display("FAIL reset_init rd=%h A=%h pc=%h flags=%b exp all zero",
                     rd, A, pc4_out_2_ex_out, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
        @(posedge clk); #1;
        checks++;
        if (rd !== 32'd0 || pc4_out_2_ex_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold rd=%h pc=%h exp 0 0", rd, pc4_out_2_ex_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rd !== 32'h33 || pc4_out_2_ex_out !== 32'h200) begin
            failures++;
            $display("FAIL reset_release rd=%h pc=%h exp 00000033 00000200", rd, pc4_out_2_ex_out);
        end
    endtask

    task automatic test_arith;
        apply_stimulus(6'b000000, 32'h0000000A, 32'h00000005, 32'h0, 32'h400);
        checks++;
        if (rd !== 32'h0000000F || A !== 32'd0 || pc4_out_2_ex_out !== 32'h400) begin
            failures++;
            $display("FAIL add_small rd=%h A=%h pc=%h exp 0000000f 0 00000400", rd, A, pc4_out_2_ex_out);
        end
        apply_stimulus(6'b000000, 32'h12345678, 32'h956BA988, 32'h0, 32'h404);
        checks++;
        if (rd !== 32'hA7A00000) begin
            failures++;
            $display("FAIL add_carry rd=%h exp a7a00000", rd);
        end
        apply_stimulus(6'b000000, 32'h14, 32'hFFF0, 32'h0, 32'h408);
        checks++;
        if (rd !== 32'h00010004) begin
            failures++;
            $display("FAIL add_16bit rd=%h exp 00010004", rd);
        end
        apply_stimulus(6'b000001, 32'hFFFFFFFF, 32'h9, 32'h2, 32'h40C);
        checks++;
        if (rd !== 32'h00000001) begin
            failures++;
            $display("FAIL addi_wrap rd=%h exp 00000001", rd);
        end
        apply_stimulus(6'b000011, 32'h0A, 32'h0, 32'hFFFFFFF5, 32'h410);
        checks++;
        if (rd !== 32'h00000015) begin
            failures++;
            $display("FAIL subi rd=%h exp 00000015", rd);
        end
        apply_stimulus(6'b000010, 32'h05, 32'h08, 32'h0, 32'h414);
        checks++;
        if (rd !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL sub_neg rd=%h exp fffffffd", rd);
        end
        apply_stimulus(6'b000100, 32'h100, 32'h08, 32'h0, 32'h418);
        checks++;
        if (rd !== 32'h00000800) begin
            failures++;
            $display("FAIL mul rd=%h exp 00000800", rd);
        end
        apply_stimulus(6'b000101, 32'h00010001, 32'h0, 32'h00010000, 32'h41C);
        checks++;
        if (rd !== 32'h00010000) begin
            failures++;
            $display("FAIL muli_trunc rd=%h exp 00010000", rd);
        end
    endtask

    task automatic test_logic;
        apply_stimulus(6'b001010, 32'h0A, 32'hF0, 32'h0, 32'h500);
        checks++;
        if (rd !== 32'h000000FA) begin
            failures++;
            $display("FAIL xor rd=%h exp 000000fa", rd);
        end
        apply_stimulus(6'b000110, 32'hF000000F, 32'h00FF0000, 32'h0, 32'h504);
        checks++;
        if (rd !== 32'hF0FF000F) begin
            failures++;
            $display("FAIL or rd=%h exp f0ff000f", rd);
        end
        apply_stimulus(6'b000111, 32'h1, 32'h0, 32'h80000000, 32'h508);
        checks++;
        if (rd !== 32'h80000001) begin
            failures++;
            $display("FAIL ori rd=%h exp 80000001", rd);
        end
        apply_stimulus(6'b001000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h50C);
        checks++;
        if (rd !== 32'h0F000F00) begin
            failures++;
            $display("FAIL and rd=%h exp 0f000f00", rd);
        end
        apply_stimulus(6'b001001, 32'h12345678, 32'hFFFFFFFF, 32'h0000FFFF, 32'h510);
        checks++;
        if (rd !== 32'h00005678) begin
            failures++;
            $display("FAIL andi rd=%h exp 00005678", rd);
        end
        apply_stimulus(6'b001011, 32'hAAAAAAAA, 32'h0, 32'hFFFFFFFF, 32'h514);
        checks++;
        if (rd !== 32'h55555555) begin
            failures++;
            $display("FAIL xori rd=%h exp 55555555", rd);
        end
    endtask

    task automatic test_memory;
        apply_stimulus(6'b001100, 32'h100, 32'h77, 32'h08, 32'h600);
        checks++;
        if (A !== 32'h108 || rd !== 32'd0 ||
            {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b110) begin
            failures++;
            $display("FAIL ldw A=%h rd=%h flags=%b exp 00000108 0 110",
                     A, rd, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
        apply_stimulus(6'b001101, 32'h100, 32'h55, 32'h08, 32'h604);
        checks++;
        if (A !== 32'h108 || rd !== 32'h55 ||
            {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b001) begin
            failures++;
            $display("FAIL stw A=%h rd=%h flags=%b exp 00000108 00000055 001",
                     A, rd, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
        apply_stimulus(6'b000001, 32'h100, 32'h55, 32'h08, 32'h608);
        checks++;
        if (A !== 32'd0 || {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b000) begin
            failures++;
            $display("FAIL mem_clear A=%h flags=%b exp 0 000",
                     A, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
    endtask

    task automatic test_branch;
        apply_stimulus(6'b001110, 32'h0, 32'h9, 32'h3, 32'h100);
        checks++;
        if (pc4_out_2_ex_out !== 32'h108 || rd !== 32'd0 || A !== 32'd0) begin
            failures++;
            $display("FAIL bz_taken pc=%h rd=%h A=%h exp 00000108 0 0", pc4_out_2_ex_out, rd, A);
        end
        apply_stimulus(6'b001110, 32'h1, 32'h9, 32'h3, 32'h100);
        checks++;
        if (pc4_out_2_ex_out !== 32'h100) begin
            failures++;
            $display("FAIL bz_not_taken pc=%h exp 00000100", pc4_out_2_ex_out);
        end
        apply_stimulus(6'b001111, 32'h1234, 32'h1234, 32'hFFFFFFFE, 32'h200);
        checks++;
        if (pc4_out_2_ex_out !== 32'h1F4) begin
            failures++;
            $display("FAIL beq_back pc=%h exp 000001f4", pc4_out_2_ex_out);
        end
        apply_stimulus(6'b001111, 32'h1234, 32'h1235, 32'hFFFFFFFE, 32'h200);
        checks++;
        if (pc4_out_2_ex_out !== 32'h200) begin
            failures++;
            $display("FAIL beq_not_taken pc=%h exp 00000200", pc4_out_2_ex_out);
        end
        apply_stimulus(6'b001110, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h4);
        checks++;
        if (pc4_out_2_ex_out !== 32'hFFFFFFF8) begin
            failures++;
            $display("FAIL bz_wrap pc=%h exp fffffff8", pc4_out_2_ex_out);
        end
        apply_stimulus(6'b010000, 32'h40, 32'h5, 32'h6, 32'h300);
        checks++;
        if (pc4_out_2_ex_out !== 32'h40 || rd !== 32'd0) begin
            failures++;
            $display("FAIL jr pc=%h rd=%h exp 00000040 0", pc4_out_2_ex_out, rd);
        end
        apply_stimulus(6'b010001, 32'h40, 32'h5, 32'h6, 32'h304);
        checks++;
        if (pc4_out_2_ex_out !== 32'h304 || rd !== 32'd0 || A !== 32'd0) begin
            failures++;
            $display("FAIL halt pc=%h rd=%h A=%h exp 00000304 0 0", pc4_out_2_ex_out, rd, A);
        end
        apply_stimulus(6'b111111, 32'h40, 32'h5, 32'h6, 32'h308);
        checks++;
        if (pc4_out_2_ex_out !== 32'h308 || rd !== 32'd0 ||
            {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b000) begin
            failures++;
            $display("FAIL undefined pc=%h rd=%h flags=%b exp 00000308 0 000",
                     pc4_out_2_ex_out, rd, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
    endtask

    task automatic test_async_reset;
        apply_stimulus(6'b001101, 32'h100, 32'h55, 32'h08, 32'h700);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd, A, pc4_out_2_ex_out} !== 96'd0 ||
            {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset rd=%h A=%h pc=%h flags=%b exp all zero",
                     rd, A, pc4_out_2_ex_out, {mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex});
        end
        @(negedge clk);
        op = 6'b000010; rs = 32'h10; rt = 32'h3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rd !== 32'h0000000D || A !== 32'd0 || mem_write_2_ex !== 1'b0) begin
            failures++;
            $display("FAIL post_reset rd=%h A=%h mw=%b exp 0000000d 0 0", rd, A, mem_write_2_ex);
        end
    endtask

    task automatic test_back_to_back;
        apply_stimulus(6'b000000, 32'h1, 32'h2, 32'h0, 32'h800);
        checks++;
        if (rd !== 32'h3) begin
            failures++;
            $display("FAIL b2b_first rd=%h exp 00000003", rd);
        end
        apply_stimulus(6'b001100, 32'h20, 32'h0, 32'h4, 32'h804);
        checks++;
        if (rd !== 32'd0 || A !== 32'h24 || mem_read_2_ex !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second rd=%h A=%h mr=%b exp 0 00000024 1", rd, A, mem_read_2_ex);
        end
        apply_stimulus(6'b001111, 32'h7, 32'h7, 32'h1, 32'h808);
        checks++;
        if (pc4_out_2_ex_out !== 32'h808 || A !== 32'd0 || mem_read_2_ex !== 1'b0) begin
            failures++;
            $display("FAIL b2b_third pc=%h A=%h mr=%b exp 00000808 0 0", pc4_out_2_ex_out, A, mem_read_2_ex);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_arith();
        test_logic();
        test_memory();
        test_branch();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 op  in  6  opcode selecting the operation.
REQ-004 rs  in  32  source operand 1 (register value).
REQ-005 rt  in  32  source operand 2 (register value).
REQ-006 i_data_2_ex  in  32  immediate, already sign-extended to 32 bits.
REQ-007 pc4_out_2_ex  in  32  PC+4 of the executing instruction.
REQ-008 rd_add_value_2_ex  in  5  destination register address; carried by the stage, no effect on any output.
REQ-009 rd  out  32  registered result.
REQ-010 A  out  32  registered memory effective address.
REQ-011 pc4_out_2_ex_out  out  32  registered next-PC (PC+4 or branch/jump target).
REQ-012 mem_read_2_ex / mem_to_reg_2_ex / mem_write_2_ex  out  1 each  registered memory control flags.

Function
REQ-013 All outputs are registered: inputs sampled on a clk rising edge appear on outputs after that edge; latency 1 cycle, throughput 1 op/cycle, no handshake.
REQ-014 Opcode map (rd result): 000000 ADD rs+rt; 000001 ADDI rs+imm; 000010 SUB rs-rt; 000011 SUBI rs-imm; 000100 MUL rs*rt; 000101 MULI rs*imm; 000110 OR; 000111 ORI; 001000 AND; 001001 ANDI; 001010 XOR; 001011 XORI (imm = i_data_2_ex).
REQ-015 Add/sub/mul: two's-complement, result truncated to low 32 bits, wrap-around on overflow, no overflow/carry output.
REQ-016 001100 LDW: A = rs+imm; rd = 0; mem_read_2_ex = 1; mem_to_reg_2_ex = 1.
REQ-017 001101 STW: A = rs+imm; rd = rt (store data); mem_write_2_ex = 1.
REQ-018 A = 0 for every opcode other than LDW/STW; memory flags = 0 except as in REQ-016/017.
REQ-019 001110 BZ: if rs == 0, pc4_out_2_ex_out = pc4_out_2_ex - 4 + (imm << 2), else pc4_out_2_ex.
REQ-020 001111 BEQ: if rs == rt, same target as REQ-019, else pc4_out_2_ex.
REQ-021 010000 JR: pc4_out_2_ex_out = rs.
REQ-022 For all other opcodes pc4_out_2_ex_out = pc4_out_2_ex; branch targets wrap modulo 2^32.
REQ-023 BZ, BEQ, JR, 010001 HALT and undefined opcodes: rd = 0, A = 0, all memory flags 0.

Reset
REQ-024 rst_n low asynchronously forces rd, A, pc4_out_2_ex_out and all memory flags to 0, independent of clk.
REQ-025 While rst_n is low outputs stay 0; the first rising edge after release registers the current inputs normally.
REQ-026 Reset asserted mid-stream discards any in-flight result; no partial state is retained.

Verification
REQ-027 ADD rs=0x0000000A rt=0x00000005 -> rd=0x0000000F; ADD rs=0x12345678 rt=0x956BA988 -> rd=0xA7A00000; ADD rs=0x14 rt=0xFFF0 -> rd=0x00010004.
REQ-028 SUBI rs=0x0A imm=0xFFFFFFF5 -> rd=0x00000015; SUB rs=0x05 rt=0x08 -> rd=0xFFFFFFFD.
REQ-029 XOR rs=0x0A rt=0xF0 -> rd=0x000000FA; MUL rs=0x100 rt=0x08 -> rd=0x00000800 (2048).
REQ-030 LDW rs=0x100 imm=0x08 -> A=0x00000108 (264), mem_read_2_ex=1, mem_to_reg_2_ex=1, rd=0; STW rs=0x100 imm=0x08 rt=0x55 -> A=0x108, rd=0x55, mem_write_2_ex=1.
REQ-031 BZ rs=0 imm=3 pc4=0x100 -> pc4_out_2_ex_out=0x108; rs=1 -> 0x100; JR rs=0x40 -> 0x40.
REQ-032 Assert rst_n low between clock edges after any op -> all outputs 0 immediately; release -> next edge produces correct result.
